// File: rtl/axi_master_pkg.sv
// Shared types and constants for the AXI burst master: FSM states, AXI response codes
// and the 4 KB burst boundary.
package axi_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned BOUNDARY_BYTES = 4096;
  localparam int unsigned BOUNDARY_W     = 12;

endpackage

// File: rtl/axi_burst_calc.sv
// Combinational burst sizing: picks the next burst length from the remaining beats,
// MAX_BURST and the distance to the next 4 KB boundary, and computes the post-burst state.
module axi_burst_calc
  import axi_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned REM_W      = 17
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REM_W-1:0]      remaining,
  output logic [7:0]            len,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [REM_W-1:0]      next_remaining
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SHIFT = $clog2(BYTES);
  localparam int unsigned CMP_W = (REM_W > 13) ? REM_W : 13;

  logic [CMP_W-1:0] to_boundary;
  logic [CMP_W-1:0] rem_ext;
  logic [CMP_W-1:0] cap;
  logic [CMP_W-1:0] pick;

  // 13 bits hold a full 4096-byte distance; everything is compared at a common width
  always_comb begin
    to_boundary = CMP_W'((13'(BOUNDARY_BYTES) - {1'b0, addr[BOUNDARY_W-1:0]}) >> SHIFT);
    rem_ext     = CMP_W'(remaining);
    cap         = CMP_W'(MAX_BURST);
    pick        = rem_ext;
    if (cap < pick) begin
      pick = cap;
    end
    if (to_boundary < pick) begin
      pick = to_boundary;
    end
    len            = 8'(pick - CMP_W'(1));
    next_addr      = addr + ADDR_WIDTH'(pick << SHIFT);
    next_remaining = REM_W'(rem_ext - pick);
  end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 burst master: splits a user command into 4 KB-safe bursts and streams data through.
// Define AXI_MASTER_ERR_ABORT_EN to end a command after the first burst that returns an error.
module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CMD_LEN_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [CMD_LEN_W-1:0]      cmd_len,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_strb,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [7:0]                awlen,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                arlen,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  localparam int unsigned REM_W = CMD_LEN_W + 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;
  logic [7:0]              beat_q, beat_d;

  logic [7:0]              burst_len;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [REM_W-1:0]        next_rem;
  logic                    last_beat;
  logic                    burst_end;
  logic                    burst_err;
  logic                    finish;

  axi_burst_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .REM_W      (REM_W)
  ) u_calc (
    .addr           (addr_q),
    .remaining      (rem_q),
    .len            (burst_len),
    .next_addr      (next_addr),
    .next_remaining (next_rem)
  );

  // Address and length come straight from stable registers so they hold through ADDR
  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awlen   = burst_len;
  assign arlen   = burst_len;
  assign wdata   = wr_data;
  assign wstrb   = wr_strb;
  assign rd_data = rdata;
  assign done    = done_q;
  assign err     = err_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    write_d   = write_q;
    err_d     = err_q;
    done_d    = 1'b0;
    beat_d    = beat_q;
    burst_end = 1'b0;
    burst_err = 1'b0;
    finish    = 1'b0;
    last_beat = (beat_q == burst_len);
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    arvalid   = 1'b0;
    wvalid    = 1'b0;
    wr_ready  = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    rd_valid  = 1'b0;
    rready    = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = REM_W'(cmd_len) + REM_W'(1);
          write_d = cmd_write;
          err_d   = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        awvalid = write_q;
        arvalid = !write_q;
        if (write_q ? awready : arready) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (write_q) begin
          wvalid   = wr_valid;
          wr_ready = wready;
          wlast    = last_beat;
          if (wr_valid && wready) begin
            beat_d = beat_q + 8'd1;
            if (last_beat) begin
              state_d = RESP;
            end
          end
        end else begin
          rd_valid = rvalid;
          rready   = rd_ready;
          if (rvalid && rd_ready) begin
            burst_err = (rresp != RESP_OKAY);
            burst_end = rlast;
          end
        end
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          burst_err = (bresp != RESP_OKAY);
          burst_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (burst_err) begin
      err_d = 1'b1;
    end

    // Burst bookkeeping: advance, then either start the next burst or complete the command
    if (burst_end) begin
      addr_d = next_addr;
      rem_d  = next_rem;
`ifdef AXI_MASTER_ERR_ABORT_EN
      finish = (next_rem == '0) || err_d;
`else
      finish = (next_rem == '0);
`endif
      if (finish) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = ADDR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      write_q <= write_d;
      err_q   <= err_d;
      done_q  <= done_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: randomized AXI slave and user streams,
// burst list predicted by a transaction-level model and compared every cycle.
module tb_axi_burst_master;
  import axi_master_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 16;
  localparam int unsigned LW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [LW-1:0]   cmd_len;
  logic [DW-1:0]   wr_data;
  logic [DW/8-1:0] wr_strb;
  logic            wr_valid, wr_ready;
  logic [DW-1:0]   rd_data;
  logic            rd_valid, rd_ready;
  logic            done, err;
  logic [AW-1:0]   awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic            awvalid, awready, arvalid, arready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;

  axi_burst_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .CMD_LEN_W  (LW)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_addr (cmd_addr), .cmd_len (cmd_len),
    .wr_data (wr_data), .wr_strb (wr_strb), .wr_valid (wr_valid), .wr_ready (wr_ready),
    .rd_data (rd_data), .rd_valid (rd_valid), .rd_ready (rd_ready),
    .done (done), .err (err),
    .awaddr (awaddr), .awlen (awlen), .awvalid (awvalid), .awready (awready),
    .araddr (araddr), .arlen (arlen), .arvalid (arvalid), .arready (arready),
    .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wvalid (wvalid), .wready (wready),
    .bresp (bresp), .bvalid (bvalid), .bready (bready),
    .rdata (rdata), .rresp (rresp), .rlast (rlast), .rvalid (rvalid), .rready (rready)
  );

  always #5 clk = ~clk;

  typedef enum int {W_IDLE, W_ADDR, W_WDATA, W_RDATA, W_RESP, W_DONE} win_e;

  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          cur_write;
  logic [31:0] cur_addr;
  int          cur_len;
  int          cur_beat;
  bit          err_exp;
  logic [31:0] exp_a[$];
  int          exp_l[$];
  logic [31:0] obs_a[$];
  int          obs_l[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference burst list: greedy split on remaining beats, MAX_BURST and 4 KB distance
  function automatic void build_bursts(input longint start, input int len);
    longint a, rem, to_b, b;
    exp_a.delete();
    exp_l.delete();
    a   = start;
    rem = len + 1;
    while (rem > 0) begin
      to_b = (4096 - (a % 4096)) / (DW / 8);
      b = rem;
      if (b > MB)   b = MB;
      if (b > to_b) b = to_b;
      exp_a.push_back(32'(a));
      exp_l.push_back(int'(b - 1));
      a   = a + b * (DW / 8);
      rem = rem - b;
    end
  endfunction

  task automatic drive_random();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_len   = LW'($urandom);
    awready   = ($urandom_range(0, 2) != 0);
    arready   = ($urandom_range(0, 2) != 0);
    wr_valid  = ($urandom_range(0, 3) != 0);
    wr_data   = $urandom;
    wr_strb   = 4'($urandom);
    wready    = ($urandom_range(0, 3) != 0);
    rvalid    = ($urandom_range(0, 3) != 0);
    rdata     = $urandom;
    rresp     = 2'($urandom);
    rlast     = 1'($urandom);
    rd_ready  = ($urandom_range(0, 3) != 0);
    bvalid    = ($urandom_range(0, 2) != 0);
    bresp     = 2'($urandom);
  endtask

  // Per-cycle comparison of every DUT output against the expected protocol window
  task automatic check_cycle(input win_e w);
    bit in_addr;
    in_addr = (w == W_ADDR);
    chk("cmd_ready", cmd_ready, (w == W_IDLE) || (w == W_DONE));
    chk("done", done, w == W_DONE);
    chk("err", err, err_exp);
    chk("awvalid", awvalid, in_addr && cur_write);
    chk("arvalid", arvalid, in_addr && !cur_write);
    if (in_addr && cur_write) begin
      chk("awaddr", awaddr, cur_addr);
      chk("awlen", awlen, cur_len);
    end
    if (in_addr && !cur_write) begin
      chk("araddr", araddr, cur_addr);
      chk("arlen", arlen, cur_len);
    end
    chk("wvalid", wvalid, (w == W_WDATA) ? wr_valid : 1'b0);
    chk("wr_ready", wr_ready, (w == W_WDATA) ? wready : 1'b0);
    chk("wlast", wlast, (w == W_WDATA) && (cur_beat == cur_len));
    if (w == W_WDATA) begin
      chk("wdata", wdata, wr_data);
      chk("wstrb", wstrb, wr_strb);
    end
    chk("rd_valid", rd_valid, (w == W_RDATA) ? rvalid : 1'b0);
    chk("rready", rready, (w == W_RDATA) ? rd_ready : 1'b0);
    if (w == W_RDATA) chk("rd_data", rd_data, rdata);
    chk("bready", bready, w == W_RESP);
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] a, input int len, input int err_burst,
                         input int aw_stall, input bit rd_toggle, input int rst_beat);
    int nissue, cyc, beat;
    bit tog, hs;
    build_bursts(longint'(a), len);
    nissue = exp_a.size();
`ifdef AXI_MASTER_ERR_ABORT_EN
    if (err_burst >= 0 && err_burst < nissue) nissue = err_burst + 1;
`endif
    obs_a.delete();
    obs_l.delete();
    cur_write = wr;
    cur_beat  = 0;
    @(negedge clk);
    drive_random();
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = LW'(len);
    #1;
    check_cycle(W_IDLE);
    err_exp = 1'b0;
    tog = 1'b1;
    for (int k = 0; k < nissue; k++) begin
      cur_addr = exp_a[k];
      cur_len  = exp_l[k];
      cyc = 0;
      hs  = 1'b0;
      while (!hs) begin
        @(negedge clk);
        drive_random();
        if (cyc < aw_stall) begin
          awready = 1'b0;
          arready = 1'b0;
          wr_valid = 1'b1; wready = 1'b1; rvalid = 1'b1; rd_ready = 1'b1;
        end else if (cyc > 40) begin
          awready = 1'b1;
          arready = 1'b1;
        end
        #1;
        check_cycle(W_ADDR);
        hs = wr ? awready : arready;
        if (hs) begin
          obs_a.push_back(wr ? awaddr : araddr);
          obs_l.push_back(int'(wr ? awlen : arlen));
        end
        cyc++;
      end
      beat = 0;
      cyc  = 0;
      while (beat <= cur_len) begin
        @(negedge clk);
        drive_random();
        if (cyc > 40) begin
          wr_valid = 1'b1; wready = 1'b1; rvalid = 1'b1; rd_ready = 1'b1;
        end
        if (rd_toggle) begin
          rd_ready = tog;
          tog      = !tog;
          rvalid   = 1'b1;
        end
        rlast    = (beat == cur_len);
        rresp    = (k == err_burst && beat == 0) ? RESP_SLVERR : RESP_OKAY;
        cur_beat = beat;
        if (wr && beat == rst_beat) begin
          wr_valid = 1'b1;
          #1;
          check_cycle(W_WDATA);
          rst = 1'b1;
          #1;
          chk("rst_wvalid", wvalid, 1'b0);
          chk("rst_wr_ready", wr_ready, 1'b0);
          chk("rst_wlast", wlast, 1'b0);
          chk("rst_cmd_ready", cmd_ready, 1'b1);
          chk("rst_awvalid", awvalid, 1'b0);
          chk("rst_bready", bready, 1'b0);
          chk("rst_done", done, 1'b0);
          chk("rst_err", err, 1'b0);
          @(negedge clk);
          rst = 1'b0;
          err_exp = 1'b0;
          return;
        end
        #1;
        check_cycle(wr ? W_WDATA : W_RDATA);
        if (wr ? (wr_valid && wready) : (rvalid && rd_ready)) begin
          if (!wr && rresp != RESP_OKAY) err_exp = 1'b1;
          beat++;
        end
        cyc++;
      end
      if (wr) begin
        cyc = 0;
        hs  = 1'b0;
        while (!hs) begin
          @(negedge clk);
          drive_random();
          if (cyc > 40) bvalid = 1'b1;
          bresp = (k == err_burst) ? (($urandom_range(0, 1) != 0) ? RESP_SLVERR : RESP_DECERR)
                                   : RESP_OKAY;
          #1;
          check_cycle(W_RESP);
          hs = bvalid;
          if (hs && bresp != RESP_OKAY) err_exp = 1'b1;
          cyc++;
        end
      end
    end
    @(negedge clk);
    drive_random();
    #1;
    check_cycle(W_DONE);
  endtask

  int t1_l[3] = '{15, 15, 7};

  initial begin
    rst       = 1'b1;
    err_exp   = 1'b0;
    cur_write = 1'b0;
    cur_addr  = '0;
    cur_len   = 0;
    cur_beat  = 0;
    drive_random();
    @(negedge clk);
    drive_random();
    #1;
    check_cycle(W_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // Pin the reference model with hand-computed burst lists
    build_bursts(0, 39);
    chk("model_t1_n", exp_a.size(), 3);
    chk("model_t1_a1", exp_a[1], 32'h40);
    chk("model_t1_l2", exp_l[2], 7);
    build_bursts(32'hFF8, 3);
    chk("model_t2_a1", exp_a[1], 32'h1000);
    chk("model_t2_l0", exp_l[0], 1);

    run_cmd(1'b1, 32'h0, 39, -1, 0, 1'b0, -1);
    chk("t1_nbursts", obs_a.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < obs_a.size()) begin
        chk("t1_awaddr", obs_a[i], 32'(i * 64));
        chk("t1_awlen", obs_l[i], t1_l[i]);
      end
    end

    run_cmd(1'b0, 32'hFF8, 3, -1, 0, 1'b0, -1);
    chk("t2_nbursts", obs_a.size(), 2);
    if (obs_a.size() == 2) begin
      chk("t2_araddr0", obs_a[0], 32'hFF8);
      chk("t2_arlen0", obs_l[0], 1);
      chk("t2_araddr1", obs_a[1], 32'h1000);
      chk("t2_arlen1", obs_l[1], 1);
    end

    run_cmd(1'b1, 32'h100, 3, -1, 5, 1'b0, -1);
    run_cmd(1'b0, 32'h200, 20, -1, 0, 1'b1, -1);

    run_cmd(1'b1, 32'h0, 39, 0, 0, 1'b0, -1);
`ifdef AXI_MASTER_ERR_ABORT_EN
    chk("t5_nbursts", obs_a.size(), 1);
`else
    chk("t5_nbursts", obs_a.size(), 3);
`endif
    chk("t5_err", err, 1'b1);

    run_cmd(1'b1, 32'h40, 7, -1, 0, 1'b0, 3);
    run_cmd(1'b1, 32'h40, 5, -1, 0, 1'b0, -1);
    chk("t6_nbursts", obs_a.size(), 1);
    if (obs_a.size() > 0) begin
      chk("t6_awaddr", obs_a[0], 32'h40);
      chk("t6_awlen", obs_l[0], 5);
    end

    run_cmd(1'b0, 32'h3FFC, 5, -1, 0, 1'b0, -1);
    chk("t7_nbursts", obs_a.size(), 2);
    if (obs_a.size() == 2) begin
      chk("t7_arlen0", obs_l[0], 0);
      chk("t7_araddr1", obs_a[1], 32'h4000);
      chk("t7_arlen1", obs_l[1], 4);
    end

    run_cmd(1'b1, 32'h10, 0, -1, 0, 1'b0, -1);
    chk("t8_nbursts", obs_a.size(), 1);
    if (obs_a.size() > 0) chk("t8_awlen", obs_l[0], 0);

    for (int i = 0; i < 40; i++) begin
      bit          wr;
      logic [31:0] a;
      int          len, eb;
      wr  = 1'($urandom);
      a   = ($urandom_range(0, 1) != 0)
              ? 32'(4096 * $urandom_range(1, 3) - 4 * $urandom_range(1, 20))
              : 32'(4 * $urandom_range(0, 2000));
      len = int'($urandom_range(0, 45));
      eb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_cmd(wr, a, len, eb, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; legal values 32, 64, 128.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum beats per AXI burst; legal range 1..256.
REQ-004 SHALL have parameter CMD_LEN_W, default 16: width of the command length field.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk (in, 1, rising edge) and rst (in, 1, async active-high).
REQ-006 SHALL have cmd_valid (in, 1), cmd_ready (out, 1) and cmd_write (in, 1): user command handshake; cmd_write 1=write, 0=read.
REQ-007 SHALL have cmd_addr (in, ADDR_WIDTH): start byte address, aligned to DATA_WIDTH/8.
REQ-008 SHALL have cmd_len (in, CMD_LEN_W): total beats minus 1.
REQ-009 SHALL have wr_data (in, DATA_WIDTH), wr_strb (in, DATA_WIDTH/8), wr_valid (in, 1) and wr_ready (out, 1): user write stream.
REQ-010 SHALL have rd_data (out, DATA_WIDTH), rd_valid (out, 1) and rd_ready (in, 1): user read stream.
REQ-011 SHALL have done (out, 1), a one-cycle command-complete pulse, and err (out, 1), a sticky error flag.
REQ-012 SHALL have awaddr/araddr (out, ADDR_WIDTH) and awlen/arlen (out, 8): AXI burst address and length.
REQ-013 SHALL have awvalid/arvalid (out, 1) and awready/arready (in, 1): AXI address handshakes.
REQ-014 SHALL have wdata (out, DATA_WIDTH), wstrb (out, DATA_WIDTH/8), wlast (out, 1), wvalid (out, 1) and wready (in, 1): AXI write data.
REQ-015 SHALL have bresp (in, 2), bvalid (in, 1) and bready (out, 1): AXI write response.
REQ-016 SHALL have rdata (in, DATA_WIDTH), rresp (in, 2), rlast (in, 1), rvalid (in, 1) and rready (out, 1): AXI read data.

Function
REQ-017 SHALL run one FSM with states IDLE -> ADDR -> DATA -> RESP (RESP for writes only) and accept a new command only in IDLE; cmd_ready=1 only in IDLE.
REQ-018 SHALL, on cmd handshake, latch addr, remaining beats (cmd_len+1) and direction, clear err, and enter ADDR on the next cycle.
REQ-019 SHALL size each burst as beats = min(remaining, MAX_BURST, beats left to the next 4 KB boundary); a/xlen = beats-1; no burst crosses 4 KB.
REQ-020 SHALL hold awvalid/arvalid high in ADDR with a stable address and length until ready; on handshake go to DATA.
REQ-021 SHALL, for write DATA, pass through wvalid=wr_valid, wr_ready=wready, wdata=wr_data and wstrb=wr_strb combinationally; assert wlast on beat index awlen; go to RESP after the wlast handshake.
REQ-022 SHALL hold bready=1 in RESP; any bresp!=OKAY sets err.
REQ-023 SHALL, for read DATA, pass through rd_valid=rvalid, rready=rd_ready and rd_data=rdata; any rresp!=OKAY sets err; the burst ends on the rlast handshake.
REQ-024 SHALL, at burst end, advance addr by beats*DATA_WIDTH/8 and subtract beats from remaining; if remaining>0, enter ADDR, else pulse done for one cycle and return to IDLE.
REQ-025 SHALL handle cmd_len=0 as a single-beat burst, and a start address 1 beat below a 4 KB boundary as a 1-beat first burst.
REQ-026 SHALL keep wr_ready, wvalid, rready and rd_valid at 0 outside DATA.

Reset
REQ-027 SHALL, on asserting rst at any time including mid-burst, immediately force IDLE with cmd_ready=1 and every valid, ready, last, done and err output at 0.
REQ-028 SHALL reset address/length registers to 0; it performs no completion of the interrupted burst.

Configuration
REQ-029 SHALL, with AXI_MASTER_ERR_ABORT_EN defined, end the command on an error after the current burst completes: remaining bursts are skipped and done pulses. Without the macro, all bursts are issued and err is flagged only.

Structure
REQ-030 SHALL put the FSM state enum, OKAY/SLVERR/DECERR resp constants and the 4 KB boundary constant in package axi_master_pkg.
REQ-031 SHALL place the burst-size and address-advance computation in sub-module axi_burst_calc (combinational); the FSM stays in axi_burst_master.

Verification
REQ-032 SHALL cover: write, addr 0x0, cmd_len=39, MAX_BURST=16 -> bursts of awlen 15,15,7 at 0x0, 0x40, 0x80; done pulses once.
REQ-033 SHALL cover: read, addr 0xFF8, cmd_len=3 -> arlen 1 at 0xFF8, then arlen 1 at 0x1000.
REQ-034 SHALL cover: awready held low for 5 cycles -> awvalid, awaddr and awlen stay stable; no wvalid.
REQ-035 SHALL cover: rd_ready toggled 1/0 during a read -> rready follows; no beat lost; rd_valid=rvalid.
REQ-036 SHALL cover: bresp=SLVERR on the first of 3 bursts -> err=1; with AXI_MASTER_ERR_ABORT_EN, done after burst 1; without it, 3 bursts are issued.
REQ-037 SHALL cover: rst asserted mid-DATA -> same-cycle wvalid=0, cmd_ready=1; a subsequent command executes normally.
